soc_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream resource (bus port, NoC link, memory channel) among PORTS requesters.
- Requesters hold the grant for a multi-beat transfer terminated by a last flag.
- An optional hold limit forces re-arbitration so one requester cannot starve the others.
- Grant index width is derived with soc_functions::clog2_width, so PORTS=1 yields a 1-bit index.

---
 rtl/soc_functions.sv | 15 +
 rtl/soc_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_soc_rr_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/soc_functions.sv
// -----------------------------------------------------------------------------
// soc_functions
//   Shared elaboration-time helpers for SoC blocks.
//
//   clog2_width(n) : bit width needed to index n items. It never returns less
//                    than 1, so a single-entry structure still gets a real
//                    1-bit index instead of a zero-width vector.
// -----------------------------------------------------------------------------
package soc_functions;

    function automatic int clog2_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/soc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// soc_rr_arbiter
//   Round-robin arbiter that shares one downstream resource among PORTS
//   requesters. The owner keeps the grant for a multi-beat transfer that ends
//   on a beat carrying last_i. An owner also loses the grant when it drops
//   req_i, or when it reaches MAX_HOLD beats while another requester waits.
//   On release the next owner is granted in the same cycle (no idle bubble).
//
// Parameters
//   PORTS     number of requesters (1..64)
//   MAX_HOLD  beats per grant before forced re-arbitration; 0 = unlimited
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   req_i        per-requester request, held for the whole transfer
//   last_i       per-requester final-beat flag (qualified by req_i)
//   ready_i      resource accepts a beat this cycle
//   gnt_o        registered one-hot grant
//   gnt_idx_o    binary index of the owner; holds its value while idle
//   gnt_valid_o  a grant is active
//   preempt_o    one-cycle pulse: owner was released by the hold limit
// -----------------------------------------------------------------------------
module soc_rr_arbiter #(
    parameter int  PORTS    = 4,
    parameter int  MAX_HOLD = 16,
    localparam int IDXW     = soc_functions::clog2_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] req_i,
    input  logic [PORTS-1:0] last_i,
    input  logic             ready_i,
    output logic [PORTS-1:0] gnt_o,
    output logic [IDXW-1:0]  gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             preempt_o
);

    localparam int              CNTW      = soc_functions::clog2_width(MAX_HOLD + 1);
    localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(PORTS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [CNTW-1:0] cnt;

    logic             own_req;
    logic             beat;
    logic             abandon;
    logic             hold_hit;
    logic             others;
    logic             force_rel;
    logic             rel;
    logic [IDXW-1:0]  next_own;
    logic [IDXW-1:0]  scan_start;
    logic [PORTS-1:0] scan_mask;
    logic             win_found;
    logic [IDXW-1:0]  win_idx;
    logic [PORTS-1:0] win_onehot;

    // First set bit of mask, scanning start, start+1, ..., wrapping at PORTS.
    // Result is {found, index}. The loop runs from the far end back towards
    // start so the closest candidate is the last one written and wins.
    function automatic logic [IDXW:0] rr_pick(input logic [PORTS-1:0] mask,
                                              input logic [IDXW-1:0]  start);
        logic [IDXW:0]   res;
        logic [IDXW-1:0] p;
        int              pos;
        res = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= PORTS) pos = pos - PORTS;
            p = IDXW'(pos);
            if (mask[p]) res = {1'b1, p};
        end
        return res;
    endfunction

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        own_req    = req_i[gnt_idx_o];
        beat       = (state == GRANT) && own_req && ready_i;
        abandon    = (state == GRANT) && !own_req;
        hold_hit   = (MAX_HOLD != 0) && beat && (cnt == HOLD_LAST);
        others     = |(req_i & ~gnt_o);
        force_rel  = hold_hit && others;
        rel        = abandon || (beat && last_i[gnt_idx_o]) || force_rel;
        next_own   = (gnt_idx_o == LAST_IDX) ? '0 : gnt_idx_o + IDXW'(1);

        // Idle arbitration starts at the pointer; handoff starts just past
        // the owner, which leaves the owner itself last in line. An owner
        // that abandoned is removed from the candidates altogether.
        scan_start = (state == IDLE) ? ptr : next_own;
        scan_mask  = abandon ? (req_i & ~gnt_o) : req_i;
        {win_found, win_idx} = rr_pick(scan_mask, scan_start);

        win_onehot          = '0;
        win_onehot[win_idx] = win_found;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            preempt_o <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            preempt_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_o     <= win_onehot;
                        gnt_idx_o <= win_idx;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr       <= next_own;
                        cnt       <= '0;
                        preempt_o <= force_rel;
                        if (win_found) begin
                            gnt_o     <= win_onehot;
                            gnt_idx_o <= win_idx;
                        end else begin
                            gnt_o <= '0;
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        // Hold limit with nobody waiting: restart the count
                        // and keep the grant.
                        cnt <= hold_hit ? '0 : cnt + CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_valid_o = |gnt_o;

endmodule

// File: tb/tb_soc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_soc_rr_arbiter
//   Directed bench for soc_rr_arbiter. Two instances share all inputs: one
//   with the default hold limit (16) and one with MAX_HOLD=4 for the
//   preemption cases. Each stimulus step queues the hand-computed outputs
//   expected after the next rising edge, tagged with the instance it applies
//   to; a monitor pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_soc_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;

    logic [3:0] g0, g1;
    logic [1:0] i0, i1;
    logic       v0, v1;
    logic       p0, p1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       pre;
        string      name;
    } exp_t;

    exp_t sb[$];

    soc_rr_arbiter #(.PORTS(4), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .ready_i(ready),
        .gnt_o(g0), .gnt_idx_o(i0), .gnt_valid_o(v0), .preempt_o(p0)
    );

    soc_rr_arbiter #(.PORTS(4), .MAX_HOLD(4)) dut_h4 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .ready_i(ready),
        .gnt_o(g1), .gnt_idx_o(i1), .gnt_valid_o(v1), .preempt_o(p1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                        input logic rdy, input bit sel, input logic [3:0] eg,
                        input logic [1:0] ei, input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        last  = lst;
        ready = rdy;
        e.sel  = sel;
        e.gnt  = eg;
        e.idx  = ei;
        e.pre  = ep;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t       e;
        logic [3:0] ag;
        logic [1:0] ai;
        logic       av, ap;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    ag = g1; ai = i1; av = v1; ap = p1;
                end else begin
                    ag = g0; ai = i0; av = v0; ap = p0;
                end
                check({e.name, "/gnt"},   8'(ag), 8'(e.gnt));
                check({e.name, "/idx"},   8'(ai), 8'(e.idx));
                check({e.name, "/valid"}, 8'(av), 8'(|e.gnt));
                check({e.name, "/pre"},   8'(ap), 8'(e.pre));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        last  = 4'b0000;
        ready = 1'b0;

        // Reset with everyone requesting, then first grant from pointer 0.
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "rst1");
        step(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "rst2");
        step(1, 4'b1111, 4'b0000, 0, 0, 4'b0001, 2'd0, 0, "first");

        // Single-beat transfers from all ports: back-to-back rotation.
        step(1, 4'b1111, 4'b1111, 1, 0, 4'b0010, 2'd1, 0, "rr1");
        step(1, 4'b1111, 4'b1111, 1, 0, 4'b0100, 2'd2, 0, "rr2");
        step(1, 4'b1111, 4'b1111, 1, 0, 4'b1000, 2'd3, 0, "rr3");
        step(1, 4'b1111, 4'b1111, 1, 0, 4'b0001, 2'd0, 0, "rr0");
        step(1, 4'b1111, 4'b1111, 1, 0, 4'b0010, 2'd1, 0, "rr1b");
        step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd1, 0, "rr_drop");

        // Port 2 five-beat transfer with ready toggling; port 1 joins at beat 3.
        step(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2'd2, 0, "hold_gnt");
        step(1, 4'b0100, 4'b0000, 1, 0, 4'b0100, 2'd2, 0, "hold_b1");
        step(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2'd2, 0, "hold_w1");
        step(1, 4'b0100, 4'b0000, 1, 0, 4'b0100, 2'd2, 0, "hold_b2");
        step(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 2'd2, 0, "hold_w2");
        step(1, 4'b0110, 4'b0000, 1, 0, 4'b0100, 2'd2, 0, "hold_b3");
        step(1, 4'b0110, 4'b0000, 0, 0, 4'b0100, 2'd2, 0, "hold_w3");
        step(1, 4'b0110, 4'b0000, 1, 0, 4'b0100, 2'd2, 0, "hold_b4");
        step(1, 4'b0110, 4'b0100, 0, 0, 4'b0100, 2'd2, 0, "last_no_rdy");
        step(1, 4'b0110, 4'b0100, 1, 0, 4'b0010, 2'd1, 0, "handoff");
        step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd1, 0, "hold_drop");

        // Hold limit of 4 on the second instance.
        step(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 2'd0, 0, "h4_rst");
        step(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "h4_gnt");
        step(1, 4'b1001, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "h4_b1");
        step(1, 4'b1001, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "h4_b2");
        step(1, 4'b1001, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "h4_b3");
        step(1, 4'b1001, 4'b0000, 1, 1, 4'b1000, 2'd3, 1, "preempt");
        step(1, 4'b1001, 4'b0000, 0, 1, 4'b1000, 2'd3, 0, "pulse_end");
        step(1, 4'b1001, 4'b1000, 1, 1, 4'b0001, 2'd0, 0, "resume");
        for (int k = 0; k < 9; k++)
            step(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "solo_hold");
        step(1, 4'b0000, 4'b0000, 0, 1, 4'b0000, 2'd0, 0, "h4_drop");

        // Owner 3 abandons; pointer wraps to 0.
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "rst3");
        step(1, 4'b1000, 4'b0000, 0, 0, 4'b1000, 2'd3, 0, "own3");
        step(1, 4'b1010, 4'b0000, 1, 0, 4'b1000, 2'd3, 0, "own3_beat");
        step(1, 4'b0010, 4'b0000, 1, 0, 4'b0010, 2'd1, 0, "abandon");
        step(1, 4'b1010, 4'b0000, 0, 0, 4'b0010, 2'd1, 0, "no_steal");
        step(1, 4'b1010, 4'b0000, 1, 0, 4'b0010, 2'd1, 0, "no_steal2");
        step(1, 4'b1010, 4'b0010, 1, 0, 4'b1000, 2'd3, 0, "handback");
        step(1, 4'b0111, 4'b0000, 0, 0, 4'b0001, 2'd0, 0, "wrap");

        // Reset during port 1's second beat; pointer must restart at 0.
        step(1, 4'b0010, 4'b0000, 0, 0, 4'b0010, 2'd1, 0, "to_p1");
        step(1, 4'b0010, 4'b0000, 1, 0, 4'b0010, 2'd1, 0, "p1_beat1");
        step(0, 4'b1010, 4'b0000, 1, 0, 4'b0000, 2'd0, 0, "mid_rst");
        step(1, 4'b1001, 4'b0000, 0, 0, 4'b0001, 2'd0, 0, "post_rst");

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
